unidad_pc: RTL and testbench

UNIDAD_PC -- requirements
Module: unidad_pc

---
 rtl/unidad_pc.sv | 119 +++++++++++
 tb/tb_unidad_pc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_pc.sv
// Fetch-address (PC) unit: sequential fetch with stall, branch redirect with
// a configurable flush bubble, halt/resume and a saturating fetch counter.
module unidad_pc #(
  parameter logic [6:0]  RESET_PC       = 7'd0,
  parameter int unsigned BRANCH_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [6:0]  branch_target,
  input  logic        halt,
  input  logic        resume,
  output logic [6:0]  pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, BUBBLE, HALT} state_t;

  // Bubble counter holds the number of flush cycles still to follow the current one.
  localparam logic [1:0] BUB_LAST = 2'(BRANCH_BUBBLES - 1);

  state_t      state_q, state_d;
  logic [6:0]  pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [1:0]  bub_q, bub_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_valid_d    = pc_valid_q;
    flush_d       = flush_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    bub_d         = bub_q;
    case (state_q)
      IDLE: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (branch_taken) begin
          pc_d       = branch_target;
          state_d    = BUBBLE;
          pc_valid_d = 1'b0;
          flush_d    = 1'b1;
          bub_d      = BUB_LAST;
        end else if (halt) begin
          state_d    = HALT;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (!stall) begin
          pc_d = pc_q + 7'd1;
          if (fetch_count_q != '1) begin
            fetch_count_d = fetch_count_q + 16'd1;
          end
        end
      end
      BUBBLE: begin
        if (branch_taken) begin
          pc_d  = branch_target;
          bub_d = BUB_LAST;
        end else if (bub_q == 2'd0) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
          flush_d    = 1'b0;
        end else begin
          bub_d = bub_q - 2'd1;
        end
      end
      HALT: begin
        if (resume) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        pc_valid_d = 1'b0;
        flush_d    = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
      bub_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
      bub_q         <= bub_d;
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign flush       = flush_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_unidad_pc.sv
// Self-checking bench for unidad_pc: directed vector table, hand sequences
// for reset corner cases and randomized traffic against a behavioural model.
module tb_unidad_pc;

  localparam int BB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, halt, resume;
  logic [6:0]  branch_target;
  logic [6:0]  pc;
  logic        pc_valid, flush, halted;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  unidad_pc #(
    .RESET_PC       (7'd0),
    .BRANCH_BUBBLES (BB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .resume        (resume),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .flush         (flush),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Reference model: a started flag, a halted flag and a count of flush
  // cycles still owed; outputs are derived from these.
  int m_pc, m_count, m_bub;
  bit m_started, m_halted;

  function automatic void m_reset();
    m_pc = 0; m_count = 0; m_bub = 0; m_started = 0; m_halted = 0;
  endfunction

  function automatic void m_step(bit st, bit br, int tg, bit hl, bit rs);
    if (!m_started) begin
      m_started = 1;
    end else if (m_bub > 0) begin
      if (br) begin m_pc = tg; m_bub = BB; end
      else m_bub = m_bub - 1;
    end else if (m_halted) begin
      if (rs) m_halted = 0;
    end else if (br) begin
      m_pc = tg; m_bub = BB;
    end else if (hl) begin
      m_halted = 1;
    end else if (!st) begin
      m_pc = (m_pc + 1) % 128;
      if (m_count < 65535) m_count = m_count + 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " pc"}, int'(pc), m_pc);
    chk({tag, " pc_valid"}, int'(pc_valid), int'(m_started && !m_halted && m_bub == 0));
    chk({tag, " flush"}, int'(flush), int'(m_bub > 0));
    chk({tag, " halted"}, int'(halted), int'(m_halted));
    chk({tag, " fetch_count"}, int'(fetch_count), m_count);
  endtask

  task automatic step(input logic st, input logic br, input logic [6:0] tg,
                      input logic hl, input logic rs);
    stall = st; branch_taken = br; branch_target = tg; halt = hl; resume = rs;
    @(posedge clk);
    m_step(st, br, int'(tg), hl, rs);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       st, br;
    logic [6:0] tgt;
    logic       hl, rs;
    logic [6:0] e_pc;
    logic       e_v, e_f, e_h;
    int         e_cnt;
  } vec_t;

  vec_t tab [37];

  initial begin
    // st br tgt hl rs | pc v f h cnt
    tab[0]  = '{0,0,7'd0,  0,0, 7'd0,  1,0,0,0};
    tab[1]  = '{0,1,7'd5,  0,0, 7'd5,  0,1,0,0};
    tab[2]  = '{0,0,7'd0,  0,0, 7'd5,  0,1,0,0};
    tab[3]  = '{0,0,7'd0,  0,0, 7'd5,  1,0,0,0};
    tab[4]  = '{1,0,7'd0,  0,0, 7'd5,  1,0,0,0};
    tab[5]  = '{1,0,7'd0,  0,0, 7'd5,  1,0,0,0};
    tab[6]  = '{1,0,7'd0,  0,0, 7'd5,  1,0,0,0};
    tab[7]  = '{0,0,7'd0,  0,0, 7'd6,  1,0,0,1};
    tab[8]  = '{0,0,7'd0,  0,0, 7'd7,  1,0,0,2};
    tab[9]  = '{0,0,7'd0,  0,0, 7'd8,  1,0,0,3};
    tab[10] = '{0,0,7'd0,  0,0, 7'd9,  1,0,0,4};
    tab[11] = '{0,0,7'd0,  0,0, 7'd10, 1,0,0,5};
    tab[12] = '{0,1,7'd100,0,0, 7'd100,0,1,0,5};
    tab[13] = '{1,0,7'd0,  1,1, 7'd100,0,1,0,5};
    tab[14] = '{0,0,7'd0,  0,0, 7'd100,1,0,0,5};
    tab[15] = '{0,1,7'd50, 0,0, 7'd50, 0,1,0,5};
    tab[16] = '{0,1,7'd20, 0,0, 7'd20, 0,1,0,5};
    tab[17] = '{0,0,7'd0,  0,0, 7'd20, 0,1,0,5};
    tab[18] = '{0,0,7'd0,  0,0, 7'd20, 1,0,0,5};
    tab[19] = '{0,1,7'd30, 0,0, 7'd30, 0,1,0,5};
    tab[20] = '{0,0,7'd0,  0,0, 7'd30, 0,1,0,5};
    tab[21] = '{0,0,7'd0,  0,0, 7'd30, 1,0,0,5};
    tab[22] = '{0,0,7'd0,  1,0, 7'd30, 0,0,1,5};
    tab[23] = '{0,1,7'd90, 1,0, 7'd30, 0,0,1,5};
    tab[24] = '{0,0,7'd0,  0,1, 7'd30, 1,0,0,5};
    tab[25] = '{0,0,7'd0,  0,0, 7'd31, 1,0,0,6};
    tab[26] = '{0,0,7'd0,  0,0, 7'd32, 1,0,0,7};
    tab[27] = '{1,1,7'd127,0,0, 7'd127,0,1,0,7};
    tab[28] = '{0,0,7'd0,  0,0, 7'd127,0,1,0,7};
    tab[29] = '{0,0,7'd0,  0,0, 7'd127,1,0,0,7};
    tab[30] = '{0,0,7'd0,  0,0, 7'd0,  1,0,0,8};
    tab[31] = '{1,0,7'd0,  1,0, 7'd0,  0,0,1,8};
    tab[32] = '{1,0,7'd0,  0,1, 7'd0,  1,0,0,8};
    tab[33] = '{1,0,7'd0,  0,0, 7'd0,  1,0,0,8};
    tab[34] = '{0,1,7'd3,  1,0, 7'd3,  0,1,0,8};
    tab[35] = '{0,0,7'd0,  0,0, 7'd3,  0,1,0,8};
    tab[36] = '{0,0,7'd0,  0,0, 7'd3,  1,0,0,8};

    stall = 0; branch_taken = 0; branch_target = '0; halt = 0; resume = 0;
    rst_n = 1'b0;
    m_reset();
    #2;
    chk_model("reset");

    // Sequential run with wrap-around
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_model("idle");
    for (int i = 0; i < 130; i++) begin
      step(0, 0, 7'd0, 0, 0);
      chk_model("seq");
    end
    chk("seq final pc", int'(pc), 1);
    chk("seq final count", int'(fetch_count), 129);

    // Directed table
    do_reset();
    chk("table idle valid", int'(pc_valid), 0);
    for (int i = 0; i < 37; i++) begin
      step(tab[i].st, tab[i].br, tab[i].tgt, tab[i].hl, tab[i].rs);
      chk($sformatf("tab%0d pc", i), int'(pc), int'(tab[i].e_pc));
      chk($sformatf("tab%0d pc_valid", i), int'(pc_valid), int'(tab[i].e_v));
      chk($sformatf("tab%0d flush", i), int'(flush), int'(tab[i].e_f));
      chk($sformatf("tab%0d halted", i), int'(halted), int'(tab[i].e_h));
      chk($sformatf("tab%0d fetch_count", i), int'(fetch_count), tab[i].e_cnt);
    end

    // Asynchronous reset in the middle of a bubble
    step(0, 1, 7'd40, 0, 0);
    chk("bubble pc", int'(pc), 40);
    chk("bubble flush", int'(flush), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async pc", int'(pc), 0);
    chk("async pc_valid", int'(pc_valid), 0);
    chk("async flush", int'(flush), 0);
    chk("async halted", int'(halted), 0);
    chk("async fetch_count", int'(fetch_count), 0);
    @(posedge clk);
    #1;
    chk("async held flush", int'(flush), 0);
    rst_n = 1'b1;
    m_reset();
    chk_model("async idle");
    step(0, 0, 7'd0, 0, 0);
    chk_model("async run");

    // Randomized traffic with occasional mid-cycle resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 7) == 0),
           7'($urandom_range(0, 127)), logic'($urandom_range(0, 15) == 0),
           logic'($urandom_range(0, 3) == 0));
      chk_model("rand");
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk_model("rand reset");
        rst_n = 1'b1;
      end
    end

    // Counter saturation
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      step(0, 0, 7'd0, 0, 0);
    end
    chk("sat count", int'(fetch_count), 65535);
    chk_model("sat");
    step(0, 0, 7'd0, 0, 0);
    chk("sat hold", int'(fetch_count), 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
